// File: rtl/tile_judge_if.sv
// Bus between the tile shift stage / player keys and the judging stage.
// Pulses (start, shift, correct_out, miss) are single-cycle strobes, valid for exactly one clk cycle.
interface tile_judge_if #(
  parameter int SCORE_W = 10
);
  logic               start;
  logic               shift;
  logic [2:0]         line_6;
  logic [3:0]         key;
  logic               correct_out;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic               game_over;
  logic [1:0]         state;

  modport master (
    output start, shift, line_6, key,
    input  correct_out, miss, score, lives, game_over, state
  );

  modport slave (
    input  start, shift, line_6, key,
    output correct_out, miss, score, lives, game_over, state
  );
endinterface

// File: rtl/tile_judge.sv
// Judges hits, wrong presses and scrolled-off tiles on the bottom row,
// keeps score and lives, and runs the IDLE/PLAY/OVER game state.
module tile_judge #(
  parameter int SCORE_W = 10,
  parameter int LIVES   = 3
) (
  input  logic         clk,
  input  logic         resetn,
  tile_judge_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = {{(SCORE_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [3:0]         r_sync1, r_sync2, r_prev;
  logic               r_correct, r_miss, r_game_over;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_lives;

  logic [3:0] w_press;
  logic [2:0] w_npress;
  logic       w_valid, w_lane_pressed;
  logic       w_hit, w_wrong, w_scrolled;
  logic [2:0] w_loss, w_lives_next;

  assign w_press  = r_sync2 & ~r_prev;
  assign w_npress = {2'b0, w_press[0]} + {2'b0, w_press[1]}
                  + {2'b0, w_press[2]} + {2'b0, w_press[3]};

  always_comb begin
    w_valid        = 1'b1;
    w_lane_pressed = 1'b0;
    case (bus.line_6)
      3'd1:    w_lane_pressed = w_press[0];
      3'd2:    w_lane_pressed = w_press[1];
      3'd3:    w_lane_pressed = w_press[2];
      3'd4:    w_lane_pressed = w_press[3];
      default: w_valid        = 1'b0;
    endcase
  end

  // r_correct doubles as the hold flag: the row still shows the hit tile for one cycle.
  assign w_hit      = !r_correct && (w_npress == 3'd1) && w_valid && w_lane_pressed;
  assign w_wrong    = !r_correct && (w_npress != 3'd0) && !w_hit;
  assign w_scrolled = !r_correct && bus.shift && w_valid && !w_hit;

  assign w_loss       = {2'b0, w_wrong} + {2'b0, w_scrolled};
  assign w_lives_next = (r_lives > w_loss) ? (r_lives - w_loss) : 3'd0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_sync1     <= 4'b0;
      r_sync2     <= 4'b0;
      r_prev      <= 4'b0;
      r_correct   <= 1'b0;
      r_miss      <= 1'b0;
      r_game_over <= 1'b0;
      r_score     <= '0;
      r_lives     <= LIVES_INIT;
    end else begin
      r_sync1   <= bus.key;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_correct <= 1'b0;
      r_miss    <= 1'b0;
      case (r_state)
        IDLE, OVER: begin
          if (bus.start) begin
            r_state     <= PLAY;
            r_score     <= '0;
            r_lives     <= LIVES_INIT;
            r_game_over <= 1'b0;
          end
        end
        PLAY: begin
          if (w_hit) begin
            r_correct <= 1'b1;
            if (r_score != '1) r_score <= r_score + SCORE_ONE;
          end
          r_miss  <= (w_loss != 3'd0);
          r_lives <= w_lives_next;
          if (w_lives_next == 3'd0) begin
            r_state     <= OVER;
            r_game_over <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.correct_out = r_correct;
  assign bus.miss        = r_miss;
  assign bus.score       = r_score;
  assign bus.lives       = r_lives;
  assign bus.game_over   = r_game_over;
  assign bus.state       = r_state;
endmodule

// File: tb/tb_tile_judge.sv
// Directed bench for tile_judge: table of single-event judging vectors plus
// hand-written sequences for game over, hold cycle, saturation and reset.
module tb_tile_judge;
  logic clk;
  logic resetn;

  tile_judge_if #(.SCORE_W(10)) bus ();

  tile_judge #(.SCORE_W(10), .LIVES(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0] line;
    logic [3:0] keys;
    logic       sh;
    logic       e_corr;
    logic       e_miss;
    int         e_score;
    int         e_lives;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_and_start();
    bus.key = 4'b0; bus.shift = 1'b0; bus.start = 1'b0; bus.line_6 = 3'd0;
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  // Rising edge on keys, wait for the judged pulse, release keys.
  task automatic press(input logic [3:0] keys, output logic corr, output logic mis);
    bus.key = keys;
    step(3);
    corr = bus.correct_out;
    mis  = bus.miss;
    bus.key = 4'b0;
    step(2);
  endtask

  initial begin
    logic c, m;
    vecs[0]  = '{3'd3, 4'b0100, 1'b0, 1'b1, 1'b0, 1, 3};
    vecs[1]  = '{3'd3, 4'b0001, 1'b0, 1'b0, 1'b1, 0, 2};
    vecs[2]  = '{3'd2, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 2};
    vecs[3]  = '{3'd2, 4'b0010, 1'b1, 1'b1, 1'b0, 1, 3};
    vecs[4]  = '{3'd0, 4'b0001, 1'b0, 1'b0, 1'b1, 0, 2};
    vecs[5]  = '{3'd3, 4'b0110, 1'b0, 1'b0, 1'b1, 0, 2};
    vecs[6]  = '{3'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 3};
    vecs[7]  = '{3'd5, 4'b0001, 1'b0, 1'b0, 1'b1, 0, 2};
    vecs[8]  = '{3'd6, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 3};
    vecs[9]  = '{3'd1, 4'b0010, 1'b1, 1'b0, 1'b1, 0, 1};
    vecs[10] = '{3'd4, 4'b1000, 1'b0, 1'b1, 1'b0, 1, 3};
    vecs[11] = '{3'd0, 4'b1111, 1'b1, 1'b0, 1'b1, 0, 2};

    // Reset state
    bus.key = 4'b0; bus.shift = 1'b0; bus.start = 1'b0; bus.line_6 = 3'd0;
    resetn = 1'b0;
    step(2);
    check("rst_state", bus.state, 0);
    check("rst_lives", bus.lives, 3);
    check("rst_score", bus.score, 0);
    check("rst_correct", bus.correct_out, 0);
    check("rst_miss", bus.miss, 0);
    check("rst_game_over", bus.game_over, 0);
    resetn = 1'b1;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("start_state", bus.state, 1);
    check("start_lives", bus.lives, 3);
    check("start_score", bus.score, 0);

    // Table: one event from a fresh PLAY state; shift lands in the press cycle
    for (int i = 0; i < 12; i++) begin
      reset_and_start();
      bus.line_6 = vecs[i].line;
      bus.key = vecs[i].keys;
      step(2);
      bus.shift = vecs[i].sh;
      step(1);
      bus.shift = 1'b0;
      check($sformatf("v%0d_correct", i), bus.correct_out, vecs[i].e_corr);
      check($sformatf("v%0d_miss", i), bus.miss, vecs[i].e_miss);
      bus.key = 4'b0;
      step(1);
      check($sformatf("v%0d_correct_low", i), bus.correct_out, 0);
      check($sformatf("v%0d_miss_low", i), bus.miss, 0);
      check($sformatf("v%0d_score", i), bus.score, vecs[i].e_score);
      check($sformatf("v%0d_lives", i), bus.lives, vecs[i].e_lives);
    end

    // Hold cycle: a shift and a second press landing there are both ignored
    reset_and_start();
    bus.line_6 = 3'd3;
    bus.key = 4'b0100;
    step(1);
    bus.key = 4'b0101;
    step(2);
    check("hold_correct", bus.correct_out, 1);
    bus.shift = 1'b1;
    step(1);
    bus.shift = 1'b0;
    check("hold_correct_once", bus.correct_out, 0);
    check("hold_no_miss", bus.miss, 0);
    step(1);
    check("hold_no_miss2", bus.miss, 0);
    check("hold_lives", bus.lives, 3);
    check("hold_score", bus.score, 1);
    bus.key = 4'b0;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("play_start_ignored", bus.score, 1);

    // Three wrong presses end the game; keys then do nothing; start restarts
    reset_and_start();
    bus.line_6 = 3'd0;
    for (int i = 0; i < 3; i++) begin
      press(4'b0001, c, m);
      check($sformatf("go_miss%0d", i), m, 1);
      check($sformatf("go_lives%0d", i), bus.lives, 2 - i);
    end
    check("go_game_over", bus.game_over, 1);
    check("go_state", bus.state, 2);
    bus.line_6 = 3'd2;
    press(4'b0010, c, m);
    check("go_key_no_hit", c, 0);
    check("go_key_no_miss", m, 0);
    check("go_score_frozen", bus.score, 0);
    check("go_lives_frozen", bus.lives, 0);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("restart_state", bus.state, 1);
    check("restart_lives", bus.lives, 3);
    check("restart_score", bus.score, 0);
    check("restart_game_over", bus.game_over, 0);

    // Score saturates at all-ones
    reset_and_start();
    bus.line_6 = 3'd3;
    for (int i = 0; i < 1023; i++) press(4'b0100, c, m);
    check("sat_score_max", bus.score, 1023);
    press(4'b0100, c, m);
    check("sat_hit_pulse", c, 1);
    check("sat_score_hold", bus.score, 1023);
    check("sat_lives", bus.lives, 3);

    // Reset during the hold cycle clears everything, including the pulse
    reset_and_start();
    bus.line_6 = 3'd1;
    bus.key = 4'b0001;
    step(3);
    check("rh_correct_pending", bus.correct_out, 1);
    resetn = 1'b0;
    step(1);
    check("rh_correct", bus.correct_out, 0);
    check("rh_miss", bus.miss, 0);
    check("rh_state", bus.state, 0);
    check("rh_score", bus.score, 0);
    check("rh_lives", bus.lives, 3);
    check("rh_game_over", bus.game_over, 0);
    resetn = 1'b1;
    bus.key = 4'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tile_judge.md
# tile_judge

Judging stage directly downstream of the tile shift register in the piano-tiles datapath. Watches the bottom row (`line_6`), the four player keys and the scroll pulse, and decides on each event: correct hit, wrong press or missed tile. Drives the shift stage's `correct_in` so the hit tile is cleared. Keeps score and lives, and runs the PLAY/OVER game state consumed by the display and speed logic.

## Interface
- `SCORE_W`, default 10: score counter width.
- `LIVES`, default 3: lives at game start, range 1..7.
- `clk  in  1`: system clock.
- `resetn  in  1`: reset, synchronous, active-low; clock `clk`.
- `start  in  1`: one-cycle start request, already debounced.
- `shift  in  1`: scroll pulse; the same pulse that drives the shift stage.
- `line_6  in  3`: bottom row from the shift stage.
  - 0 = empty.
  - 1..4 = tile in lane 0..3.
  - 5..7 never occur; they are judged as empty.
- `key  in  4`: raw asynchronous lane keys, active-high; bit i = lane i.
- `correct_out  out  1`: one-cycle pulse, wired to the shift stage `correct_in`.
- `miss  out  1`: one-cycle pulse on a life loss.
- `score  out  SCORE_W`: count of correct hits.
- `lives  out  3`: lives remaining.
- `game_over  out  1`: high while in state OVER.
- `state  out  2`: game state. IDLE=0, PLAY=1, OVER=2.

## Operation
- **Key input path**
  - Each `key` bit passes through a 2-flop synchronizer, then a previous-value register.
  - `press[i]` = synced & ~prev, one cycle per rising edge.
  - `npress` = number of set bits in `press`.
- **Reset**: state IDLE, score 0, lives = LIVES. `correct_out`, `miss` and `game_over` are 0. Synchronizer and prev registers clear to 0.
- **FSM**
  - IDLE: `start` -> PLAY, score <= 0, lives <= LIVES.
  - PLAY: lives reaching 0 -> OVER. `start` is ignored.
  - OVER: `start` -> PLAY, with the same reinitialisation as from IDLE.
  - `press` and `shift` are ignored outside PLAY.
- **Judging in PLAY**, evaluated each cycle with `hold` = registered `correct_out`:
  - hit = !hold & npress==1 & line_6 in 1..4 & press[line_6-1].
  - wrong = !hold & npress>=1 & !hit. This covers an empty row, the wrong lane, and multiple presses in one cycle.
  - scrolled = !hold & shift & line_6 in 1..4 & !hit.
  - hit -> `correct_out` <= 1 next cycle; score <= score+1, saturating at all-ones.
  - loss = wrong + scrolled (0..2). lives <= max(lives-loss, 0). `miss` <= (loss != 0).
  - If the new lives value is 0, state -> OVER on the same edge.
- **Hold cycle**
  - While `correct_out` is high, `line_6` still shows the hit tile, and the shift stage drops any `shift` that cycle (correct has priority there).
  - Therefore all judging is suppressed during the hold cycle: presses are discarded and `shift` causes no miss.
- A hit together with `shift` in the same cycle is a hit only: scrolled is 0, and no life is lost.

## Timing
- All outputs are registered.
- A key rising before edge N gives `press` in cycle N+1..N+2, and `correct_out`/`miss` high after edge N+2.
- From `shift` with an unhit tile to `miss`: 1 cycle.
- From `start` to `state`=PLAY: 1 cycle.
- From the final life loss to `game_over`: same edge as `lives`=0.
- `correct_out` is never high two cycles in a row.
- `resetn` low mid-game overrides everything on the next edge, including a pending `correct_out`.

## Test plan
- Reset, then `start`: state=1, lives=3, score=0, all pulses 0.
- line_6=3, press key[2] alone: `correct_out` pulses exactly once, 3 cycles after the key rises; score=1; lives stay 3.
- line_6=3, press key[0]: `miss` for 1 cycle; lives=2; score unchanged; no `correct_out`.
- line_6=2 and `shift` with no key: `miss`, lives 3->2. Then the hit on key[1] coincides with `shift`: score+1, no miss.
- Three misses in a row: lives reach 0, `game_over`=1, state=2, and further keys change nothing. Then `start`: state=1, lives=3, score=0.
- Two keys rising in one cycle on a valid tile: wrong press, lives-1. Score at 1023 plus a hit: score stays 1023. `resetn` low during a hold cycle: all outputs return to reset values.
